// File: rtl/demux_pkg.sv
// Shared encodings for the 1-to-2 stream demultiplexer: FSM states, channel ids
// and the helper that resolves which output channel the current input beat targets.
package demux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT0 = 2'd1,
        PKT1 = 2'd2
    } state_t;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    // Outside a packet the live select decides; inside one the locked channel does.
    function automatic logic targetOf(input state_t state, input logic sel);
        logic ch;
        ch = sel;
        if (state == PKT0) ch = CH0;
        if (state == PKT1) ch = CH1;
        return ch;
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry valid/ready output register. A load in the same cycle as a drain keeps
// the slot full with the new beat so a channel sustains one beat per cycle.
module demux_out_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    output logic              o_free
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;
    assign o_free  = !r_valid || i_ready;

endmodule

// File: rtl/demux_1to2_stream.sv
// 1-to-2 packet stream demultiplexer: channel picked by in_sel on a packet's first beat
// and held until in_last. Define DEMUX_COUNT_EN to add per-channel delivered-beat counters.
module demux_1to2_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef DEMUX_COUNT_EN
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  beat_cnt0,
    output logic [CNT_W-1:0]  beat_cnt1,
`endif
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out0_valid,
    output logic              out0_last,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic              out1_valid,
    output logic              out1_last,
    input  logic              out1_ready
);

    state_t r_state;
    state_t w_nextState;
    logic   w_target;
    logic   w_accept;
    logic   w_free0;
    logic   w_free1;
    logic   w_load0;
    logic   w_load1;

    // Only the targeted slot may stall the producer; reset also holds it off.
    assign w_target = targetOf(r_state, in_sel);
    assign in_ready = rst_n && ((w_target == CH1) ? w_free1 : w_free0);
    assign w_accept = in_valid && in_ready;
    assign w_load0  = w_accept && (w_target == CH0);
    assign w_load1  = w_accept && (w_target == CH1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        if (w_accept) begin
            if (in_last)
                w_nextState = IDLE;
            else if (r_state == IDLE)
                w_nextState = (in_sel == CH1) ? PKT1 : PKT0;
        end
    end

    demux_out_slot #(.DATA_W(DATA_W)) u_slot0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load0),
        .i_data  (in_data),
        .i_last  (in_last),
        .i_ready (out0_ready),
        .o_valid (out0_valid),
        .o_data  (out0_data),
        .o_last  (out0_last),
        .o_free  (w_free0)
    );

    demux_out_slot #(.DATA_W(DATA_W)) u_slot1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load1),
        .i_data  (in_data),
        .i_last  (in_last),
        .i_ready (out1_ready),
        .o_valid (out1_valid),
        .o_data  (out1_data),
        .o_last  (out1_last),
        .o_free  (w_free1)
    );

`ifdef DEMUX_COUNT_EN
    logic [CNT_W-1:0] r_beatCnt0;
    logic [CNT_W-1:0] r_beatCnt1;

    // Counters wrap naturally at full scale; clear takes priority over a delivery.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beatCnt0 <= '0;
            r_beatCnt1 <= '0;
        end else if (cnt_clr) begin
            r_beatCnt0 <= '0;
            r_beatCnt1 <= '0;
        end else begin
            if (out0_valid && out0_ready) r_beatCnt0 <= r_beatCnt0 + 1'b1;
            if (out1_valid && out1_ready) r_beatCnt1 <= r_beatCnt1 + 1'b1;
        end
    end

    assign beat_cnt0 = r_beatCnt0;
    assign beat_cnt1 = r_beatCnt1;
`endif

endmodule
